// File: rtl/qtable_update_ctrl.sv
// qtable_update_ctrl: sequencer for a single Q-table RAM that applies one
// Q-learning update per request and reports the greedy next action.
//   Q(s,a) += alpha * (r + gamma * max_a' Q(s',a') - Q(s,a))
//   alpha = 2^-ALPHA_SHIFT, gamma = 1 - 2^-GAMMA_SHIFT
// The RAM has a registered read port (1-cycle latency) and an independent
// write port. Phases: IDLE -> READ (NA+1) -> DRAIN -> CALC -> WRITE -> DONE.
// Optional build macro QCTRL_SATURATE_EN: clamp the new Q value to the
// DATA_WIDTH signed range instead of wrapping it.
module qtable_update_ctrl #(
  parameter int STATE_BITS  = 6,
  parameter int ACTION_BITS = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_SHIFT = 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_start,
  input  logic        [STATE_BITS-1:0]         i_state,
  input  logic        [ACTION_BITS-1:0]        i_action,
  input  logic        [STATE_BITS-1:0]         i_next_state,
  input  logic signed [DATA_WIDTH-1:0]         i_reward,
  input  logic                                 i_terminal,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic        [ACTION_BITS-1:0]        o_best_action,
  output logic signed [DATA_WIDTH-1:0]         o_q_new,
  output logic        [STATE_BITS+ACTION_BITS-1:0] o_q_addr_r,
  output logic        [STATE_BITS+ACTION_BITS-1:0] o_q_addr_w,
  output logic                                 o_q_read_en,
  output logic                                 o_q_write_en,
  output logic signed [DATA_WIDTH-1:0]         o_q_wdata,
  input  logic signed [DATA_WIDTH-1:0]         i_q_rdata
);

  localparam int NA = 1 << ACTION_BITS;
  localparam int AW = STATE_BITS + ACTION_BITS;
  localparam int CW = DATA_WIDTH + 3;

  localparam logic [ACTION_BITS:0]   CNT_LAST = (ACTION_BITS + 1)'(NA);
  localparam logic [ACTION_BITS:0]   CNT_ONE  = (ACTION_BITS + 1)'(1);
  localparam logic [ACTION_BITS-1:0] ACT_ONE  = ACTION_BITS'(1);

  localparam logic signed [CW-1:0] Q_MAX_X = {4'b0000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [CW-1:0] Q_MIN_X = {4'b1111, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_CALC  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]                   state;
  logic [ACTION_BITS:0]         cnt;
  logic [STATE_BITS-1:0]        s_lat;
  logic [ACTION_BITS-1:0]       a_lat;
  logic [STATE_BITS-1:0]        ns_lat;
  logic signed [DATA_WIDTH-1:0] r_lat;
  logic                         term_lat;
  logic [AW-1:0]                addr_r;
  logic [AW-1:0]                addr_w;

  logic                         vld_p1;
  logic [ACTION_BITS:0]         idx_p1;
  logic signed [DATA_WIDTH-1:0] q_cur;
  logic signed [DATA_WIDTH-1:0] max_q;
  logic [ACTION_BITS-1:0]       best_a;

  logic signed [DATA_WIDTH-1:0] q_new_p2;
  logic [ACTION_BITS-1:0]       best_p2;

  logic signed [CW-1:0] q_cur_x, r_x, m_x, gm_x, td_x, qn_x;

  // Narrow the widened update result back to DATA_WIDTH (clamp or wrap).
  function automatic logic signed [DATA_WIDTH-1:0] reduce_q(input logic signed [CW-1:0] v);
`ifdef QCTRL_SATURATE_EN
    if (v > Q_MAX_X)
      reduce_q = Q_MAX_X[DATA_WIDTH-1:0];
    else if (v < Q_MIN_X)
      reduce_q = Q_MIN_X[DATA_WIDTH-1:0];
    else
      reduce_q = v[DATA_WIDTH-1:0];
`else
    reduce_q = v[DATA_WIDTH-1:0];
`endif
  endfunction

  // Control FSM: accept, sequence the read addresses, then write and finish.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      s_lat    <= '0;
      a_lat    <= '0;
      ns_lat   <= '0;
      r_lat    <= '0;
      term_lat <= 1'b0;
      addr_r   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state    <= S_READ;
            cnt      <= '0;
            s_lat    <= i_state;
            a_lat    <= i_action;
            ns_lat   <= i_next_state;
            r_lat    <= i_reward;
            term_lat <= i_terminal;
            addr_r   <= {i_state, i_action};
          end
        end
        S_READ: begin
          if (cnt == CNT_LAST) begin
            state <= S_DRAIN;
          end else begin
            // issue cnt+1 reads Q(s', cnt)
            addr_r <= {ns_lat, cnt[ACTION_BITS-1:0]};
            cnt    <= cnt + CNT_ONE;
          end
        end
        S_DRAIN: state <= S_CALC;
        S_CALC:  state <= S_WRITE;
        S_WRITE: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // --- stage p1: read data returns; capture Q(s,a) and track the running max ---
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
      q_cur  <= '0;
      max_q  <= '0;
      best_a <= '0;
    end else begin
      vld_p1 <= (state == S_READ);
      idx_p1 <= cnt;
      if (vld_p1) begin
        if (idx_p1 == '0) begin
          q_cur <= i_q_rdata;
        end else if ((idx_p1 == CNT_ONE) || (i_q_rdata > max_q)) begin
          // first next-state value seeds; strictly greater keeps the lowest index on ties
          max_q  <= i_q_rdata;
          best_a <= idx_p1[ACTION_BITS-1:0] - ACT_ONE;
        end
      end
    end
  end

  // Update arithmetic, widened by 3 bits so no intermediate can overflow.
  always_comb begin
    q_cur_x = {{3{q_cur[DATA_WIDTH-1]}}, q_cur};
    r_x     = {{3{r_lat[DATA_WIDTH-1]}}, r_lat};
    m_x     = term_lat ? '0 : {{3{max_q[DATA_WIDTH-1]}}, max_q};
    gm_x    = m_x - (m_x >>> GAMMA_SHIFT);
    td_x    = r_x + gm_x - q_cur_x;
    qn_x    = q_cur_x + (td_x >>> ALPHA_SHIFT);
  end

  // --- stage p2: register the result, greedy action and write address in CALC ---
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      q_new_p2 <= '0;
      best_p2  <= '0;
      addr_w   <= '0;
    end else if (state == S_CALC) begin
      q_new_p2 <= reduce_q(qn_x);
      best_p2  <= best_a;
      addr_w   <= {s_lat, a_lat};
    end
  end

  assign o_busy        = (state != S_IDLE);
  assign o_done        = (state == S_DONE);
  assign o_q_read_en   = (state == S_READ);
  assign o_q_write_en  = (state == S_WRITE);
  assign o_q_addr_r    = addr_r;
  assign o_q_addr_w    = addr_w;
  assign o_q_wdata     = q_new_p2;
  assign o_q_new       = q_new_p2;
  assign o_best_action = best_p2;

endmodule

// File: tb/tb_qtable_update_ctrl.sv
// tb_qtable_update_ctrl: directed bench for qtable_update_ctrl (default build)
// with a behavioural Q-table RAM of 1-cycle read latency.
module tb_qtable_update_ctrl;

  localparam int SB = 6;
  localparam int AB = 2;
  localparam int DW = 32;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b0;
  logic                 i_start = 1'b0;
  logic [SB-1:0]        i_state = '0;
  logic [AB-1:0]        i_action = '0;
  logic [SB-1:0]        i_next_state = '0;
  logic signed [DW-1:0] i_reward = '0;
  logic                 i_terminal = 1'b0;
  logic                 o_busy;
  logic                 o_done;
  logic [AB-1:0]        o_best_action;
  logic signed [DW-1:0] o_q_new;
  logic [SB+AB-1:0]     o_q_addr_r;
  logic [SB+AB-1:0]     o_q_addr_w;
  logic                 o_q_read_en;
  logic                 o_q_write_en;
  logic signed [DW-1:0] o_q_wdata;
  logic signed [DW-1:0] i_q_rdata = '0;

  logic signed [DW-1:0] mem [0:255];
  logic                 tb_we = 1'b0;
  logic [7:0]           tb_wa = '0;
  logic signed [DW-1:0] tb_wd = '0;

  int total  = 0;
  int passed = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  qtable_update_ctrl dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_state      (i_state),
    .i_action     (i_action),
    .i_next_state (i_next_state),
    .i_reward     (i_reward),
    .i_terminal   (i_terminal),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_best_action(o_best_action),
    .o_q_new      (o_q_new),
    .o_q_addr_r   (o_q_addr_r),
    .o_q_addr_w   (o_q_addr_w),
    .o_q_read_en  (o_q_read_en),
    .o_q_write_en (o_q_write_en),
    .o_q_wdata    (o_q_wdata),
    .i_q_rdata    (i_q_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Q-table RAM: registered read, DUT write port, bench preload port.
  always @(posedge i_clk) begin
    if (o_q_read_en) i_q_rdata <= mem[o_q_addr_r];
    if (o_q_write_en) mem[o_q_addr_w] <= o_q_wdata;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end

  // Count RAM accesses issued by the DUT.
  always @(negedge i_clk) begin
    if (o_q_write_en) wr_cnt++;
    if (o_q_read_en) rd_cnt++;
  end

  task automatic poke(input logic [SB-1:0] s, input logic [AB-1:0] a, input logic signed [DW-1:0] v);
    @(negedge i_clk);
    tb_we = 1'b1; tb_wa = {s, a}; tb_wd = v;
    @(negedge i_clk);
    tb_we = 1'b0;
  endtask

  // Present a request for one cycle; returns at the negedge of cycle 0.
  task automatic start_req(input logic [SB-1:0] s, input logic [AB-1:0] a,
                           input logic [SB-1:0] ns, input logic signed [DW-1:0] r,
                           input logic term);
    @(negedge i_clk);
    i_state = s; i_action = a; i_next_state = ns; i_reward = r; i_terminal = term;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (o_done !== 1'b1 && cyc < 40) begin
      @(negedge i_clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", o_busy); else passed++;
    total++; if (o_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", o_done); else passed++;
    total++; if ({o_q_read_en, o_q_write_en} !== 2'b00) $display("FAIL reset_en: got %b expected 00", {o_q_read_en, o_q_write_en}); else passed++;
    total++; if (o_q_new !== 32'sd0) $display("FAIL reset_qnew: got %0d expected 0", o_q_new); else passed++;
    total++; if ({o_q_addr_r, o_q_addr_w, o_best_action} !== '0) $display("FAIL reset_addr: got %h expected 0", {o_q_addr_r, o_q_addr_w, o_best_action}); else passed++;
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  task automatic test_basic();
    int cyc, rd0, wr0;
    poke(6'd5, 2'd2, 100);
    poke(6'd9, 2'd0, 20);
    poke(6'd9, 2'd1, 80);
    poke(6'd9, 2'd2, 40);
    poke(6'd9, 2'd3, 80);
    rd0 = rd_cnt; wr0 = wr_cnt;
    start_req(6'd5, 2'd2, 6'd9, 8, 1'b0);
    total++; if (o_busy !== 1'b1) $display("FAIL basic_busy: got %b expected 1", o_busy); else passed++;
    wait_done(cyc);
    // gm = 80-40 = 40; td = 8+40-100 = -52; -52>>>2 = -13; 100-13 = 87
    total++; if (cyc !== 8) $display("FAIL basic_latency: got %0d expected 8", cyc); else passed++;
    total++; if (o_q_new !== 32'sd87) $display("FAIL basic_qnew: got %0d expected 87", o_q_new); else passed++;
    total++; if (o_best_action !== 2'd1) $display("FAIL basic_best: got %0d expected 1", o_best_action); else passed++;
    total++; if (o_q_addr_w !== 8'h16) $display("FAIL basic_waddr: got %h expected 16", o_q_addr_w); else passed++;
    total++; if (mem[8'h16] !== 32'sd87) $display("FAIL basic_ram: got %0d expected 87", mem[8'h16]); else passed++;
    total++; if (rd_cnt - rd0 !== 5) $display("FAIL basic_reads: got %0d expected 5", rd_cnt - rd0); else passed++;
    total++; if (wr_cnt - wr0 !== 1) $display("FAIL basic_writes: got %0d expected 1", wr_cnt - wr0); else passed++;
    @(negedge i_clk);
    @(negedge i_clk);
    total++; if (o_busy !== 1'b0) $display("FAIL basic_idle: got %b expected 0", o_busy); else passed++;
    total++; if (o_q_new !== 32'sd87 || o_best_action !== 2'd1) $display("FAIL basic_hold: got %0d/%0d expected 87/1", o_q_new, o_best_action); else passed++;
  endtask

  task automatic test_terminal();
    int cyc, rd0;
    poke(6'd3, 2'd1, 100);
    poke(6'd12, 2'd0, 500);
    poke(6'd12, 2'd1, -3);
    poke(6'd12, 2'd2, 7);
    poke(6'd12, 2'd3, 900);
    rd0 = rd_cnt;
    start_req(6'd3, 2'd1, 6'd12, 20, 1'b1);
    wait_done(cyc);
    // m = 0; td = 20-100 = -80; -80>>>2 = -20; 100-20 = 80
    total++; if (o_q_new !== 32'sd80) $display("FAIL term_qnew: got %0d expected 80", o_q_new); else passed++;
    total++; if (o_best_action !== 2'd3) $display("FAIL term_best: got %0d expected 3", o_best_action); else passed++;
    total++; if (rd_cnt - rd0 !== 5) $display("FAIL term_reads: got %0d expected 5", rd_cnt - rd0); else passed++;
    total++; if (mem[8'h0D] !== 32'sd80) $display("FAIL term_ram: got %0d expected 80", mem[8'h0D]); else passed++;
  endtask

  task automatic test_saturation();
    int cyc;
    poke(6'd10, 2'd0, 32'sh7FFFFFF0);
    poke(6'd11, 2'd0, 0);
    poke(6'd11, 2'd1, 32'sh7FFFFFFF);
    poke(6'd11, 2'd2, 5);
    poke(6'd11, 2'd3, 32'sh7FFFFFFF);
    start_req(6'd10, 2'd0, 6'd11, 32'sh7FFFFFFF, 1'b0);
    wait_done(cyc);
    // wrap build: 0x7FFFFFF0 + (0x4000000F >>> 2) = 0x8FFFFFF3
    total++; if (o_q_new !== 32'sh8FFFFFF3) $display("FAIL sat_qnew: got %h expected 8ffffff3", o_q_new); else passed++;
    total++; if (o_best_action !== 2'd1) $display("FAIL sat_best: got %0d expected 1", o_best_action); else passed++;
  endtask

  task automatic test_busy();
    int cyc, wr0;
    poke(6'd20, 2'd3, -40);
    poke(6'd21, 2'd0, -10);
    poke(6'd21, 2'd1, -20);
    poke(6'd21, 2'd2, -5);
    poke(6'd21, 2'd3, -30);
    poke(6'd30, 2'd1, 1000);
    wr0 = wr_cnt;
    start_req(6'd20, 2'd3, 6'd21, 4, 1'b0);
    cyc = 0;
    while (o_done !== 1'b1 && cyc < 40) begin
      if (cyc == 2 || cyc == 7) begin
        i_start = 1'b1; i_state = 6'd30; i_action = 2'd1; i_next_state = 6'd31; i_reward = 999;
      end else begin
        i_start = 1'b0;
      end
      @(negedge i_clk);
      cyc++;
    end
    i_start = 1'b0;
    // m=-5; gm = -5-(-3) = -2; td = 4-2+40 = 42; 42>>>2 = 10; -40+10 = -30
    total++; if (cyc !== 8) $display("FAIL busy_latency: got %0d expected 8", cyc); else passed++;
    total++; if (o_q_new !== -32'sd30) $display("FAIL busy_qnew: got %0d expected -30", o_q_new); else passed++;
    total++; if (o_best_action !== 2'd2) $display("FAIL busy_best: got %0d expected 2", o_best_action); else passed++;
    total++; if (wr_cnt - wr0 !== 1) $display("FAIL busy_writes: got %0d expected 1", wr_cnt - wr0); else passed++;
    total++; if (mem[8'h79] !== 32'sd1000) $display("FAIL busy_other_ram: got %0d expected 1000", mem[8'h79]); else passed++;
    total++; if (mem[8'h53] !== -32'sd30) $display("FAIL busy_ram: got %0d expected -30", mem[8'h53]); else passed++;
    @(negedge i_clk);
    @(negedge i_clk);
    total++; if (o_busy !== 1'b0) $display("FAIL busy_no_restart: got %b expected 0", o_busy); else passed++;
  endtask

  task automatic test_reset_abort();
    int cyc, wr0;
    poke(6'd40, 2'd1, 64);
    poke(6'd41, 2'd0, 0);
    poke(6'd41, 2'd1, 16);
    poke(6'd41, 2'd2, 16);
    poke(6'd41, 2'd3, 4);
    wr0 = wr_cnt;
    start_req(6'd40, 2'd1, 6'd41, -8, 1'b0);
    repeat (3) @(negedge i_clk);
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    #1;
    total++; if ({o_busy, o_q_read_en, o_done} !== 3'b000) $display("FAIL abort_ctrl: got %b expected 000", {o_busy, o_q_read_en, o_done}); else passed++;
    total++; if (o_q_new !== 32'sd0 || o_q_addr_r !== 8'h00) $display("FAIL abort_data: got %0d/%h expected 0/00", o_q_new, o_q_addr_r); else passed++;
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    total++; if (wr_cnt !== wr0) $display("FAIL abort_no_write: got %0d expected %0d", wr_cnt, wr0); else passed++;
    total++; if (mem[8'hA1] !== 32'sd64) $display("FAIL abort_ram: got %0d expected 64", mem[8'hA1]); else passed++;
    start_req(6'd40, 2'd1, 6'd41, -8, 1'b0);
    wait_done(cyc);
    // gm = 16-8 = 8; td = -8+8-64 = -64; -64>>>2 = -16; 64-16 = 48
    total++; if (cyc !== 8) $display("FAIL abort_retry_latency: got %0d expected 8", cyc); else passed++;
    total++; if (o_q_new !== 32'sd48 || o_best_action !== 2'd1) $display("FAIL abort_retry: got %0d/%0d expected 48/1", o_q_new, o_best_action); else passed++;
    total++; if (wr_cnt - wr0 !== 1) $display("FAIL abort_retry_writes: got %0d expected 1", wr_cnt - wr0); else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    poke(6'd7, 2'd0, 10);
    poke(6'd7, 2'd1, 0);
    poke(6'd7, 2'd2, 0);
    poke(6'd7, 2'd3, 0);
    start_req(6'd7, 2'd0, 6'd7, 0, 1'b0);
    wait_done(cyc);
    // gm = 10-5 = 5; td = 0+5-10 = -5; -5>>>2 = -2; 10-2 = 8
    total++; if (o_q_new !== 32'sd8 || o_best_action !== 2'd0) $display("FAIL b2b_first: got %0d/%0d expected 8/0", o_q_new, o_best_action); else passed++;
    start_req(6'd7, 2'd0, 6'd7, 0, 1'b0);
    wait_done(cyc);
    // reads pre-update 8: gm = 8-4 = 4; td = -4; -4>>>2 = -1; 8-1 = 7
    total++; if (cyc !== 8) $display("FAIL b2b_latency: got %0d expected 8", cyc); else passed++;
    total++; if (o_q_new !== 32'sd7) $display("FAIL b2b_second: got %0d expected 7", o_q_new); else passed++;
    total++; if (mem[8'h1C] !== 32'sd7) $display("FAIL b2b_ram: got %0d expected 7", mem[8'h1C]); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_terminal();
    test_saturation();
    test_busy();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
